npu_tile_os: RTL and testbench
==============================

Name: npu_tile_os

Overview:
- Parametrised output-stationary systolic tile: the next-generation compute core of the NPU.
- Replaces the fixed 4x4 array-plus-PPU wrapper with one block that does three things:
  - accepts K-slices of activations/weights over an AXI4-Stream slave;
  - accumulates a ROWS x COLS INT8 matrix product of arbitrary depth K;
  - requantizes (round, shift, optional ReLU, saturate) and streams result rows out with full backpressure.
- Sits between the DMA/stream fabric and the output buffer.

Parameters:
- ROWS, 4, array rows (activation lanes, output beats per job)
- COLS, 4, array columns (weight lanes, elements per output beat)
- DATA_WIDTH, 8, signed operand/result width
- ACC_WIDTH, 32, signed accumulator width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_shift  in  5  requant right-shift, sampled on first accepted beat of a job
- cfg_relu  in  1  clamp negatives to 0, sampled with cfg_shift
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  (ROWS+COLS)*DATA_WIDTH  a[i] at [i*DW+:DW] (i<ROWS); b[j] at [(ROWS+j)*DW+:DW]
- s_axis_tlast  in  1  final K-slice of job
- m_axis_tvalid  out  1  result beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  COLS*DATA_WIDTH  result row r, element j at [j*DW+:DW]
- m_axis_tlast  out  1  high on row ROWS-1
- busy  out  1  high in LOAD/FLUSH/DRAIN
- k_count  out  16  beats accepted in current/last job, saturates at 16'hFFFF

Behaviour:

Reset:
- rst in any state returns to IDLE and clears accumulators, skew regs, row counter and k_count.
- After reset: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, busy=0.
- An in-flight job is discarded and no partial output is emitted.

FSM states: IDLE, LOAD, FLUSH, DRAIN.

- IDLE:
  - tready=1.
  - On handshake: latch cfg, set k_count=1, inject beat.
  - Next state: FLUSH if tlast, else LOAD.
- LOAD:
  - tready=1.
  - On each handshake: inject beat and increment k_count (saturating).
  - Without tvalid: inject zeros. Bubbles are legal and do not change the result.
  - Handshake with tlast -> FLUSH.
- FLUSH:
  - tready=0.
  - Inject zeros for exactly ROWS+COLS-1 cycles (down-counter), then -> DRAIN.
- DRAIN:
  - tready=0, m_axis_tvalid=1.
  - Row counter r starts at 0; tdata = requant(acc[r][*]); tlast = (r==ROWS-1).
  - On handshake: r++.
  - On handshake with r==ROWS-1: clear all accumulators, r=0, -> IDLE.
  - tdata/tlast are held stable while tready=0.

Array:
- Row i input is delayed i cycles; column j input is delayed j cycles (skew registers).
- PE(i,j):
  - acc += a*b, signed, full-precision product sign-extended to ACC_WIDTH.
  - Accumulator wraps mod 2^ACC_WIDTH; no overflow detection.
  - a registered right, b registered down.
- Latency: first m_axis_tvalid occurs ROWS+COLS cycles after the tlast handshake.

Requant, per element, combinational from acc and latched cfg:
- If shift>0: add 1<<(shift-1) (round half-up), then arithmetic >>> shift.
- If relu: negative -> 0.
- Saturate to [-2^(DW-1), 2^(DW-1)-1].
- All intermediate math is done at ACC_WIDTH+1 bits.

Boundaries:
- K=1 (tlast on first beat) is legal.
- In DRAIN with m_axis_tready low indefinitely: holds and accepts no input.
- cfg changes mid-job are ignored.
- k_count holds its value in IDLE until the next job's first beat.

Decomposition:
- npu_pkg:
  - npu_tile_state_e enum
  - requant function (acc, shift, relu) parametrised via localparams
  - RND/SAT localparams
- Sub-module npu_pe: one MAC cell with ports a_in/b_in/a_out/b_out/acc, clear and enable; instantiated ROWS x COLS via generate.
- Skew registers and FSM live in npu_tile_os.

Test Plan:
- Identity: K=4, A rows = [1,2,3,4]*(r+1), B = I4, shift=0, relu=0 -> row r = A row r. tlast only on beat 4. First tvalid 8 cycles after tlast handshake.
- Saturation/round: K=4, all a=b=-128, shift=8 -> acc=65536 -> 256 -> 127 everywhere. With all a=127, b=-128: acc=-65024 -> -254 -> -128.
- ReLU and rounding: K=1, a=b giving acc=-3 and +3, shift=1, relu=1 -> 0 and 2 (3+1>>1).
- Input bubbles: same job as Identity with tvalid deasserted for 3 random cycles between beats -> identical results; k_count=4.
- Output backpressure: m_axis_tready toggles 1-0-0-1 during DRAIN -> tdata stable while stalled, exactly ROWS beats, s_axis_tready=0 until the final handshake.
- Reset mid-DRAIN after 2 rows, then a new K=1 job with a=1, b=1 -> all outputs 1 (no residue from the aborted job), m_axis_tvalid=0 during reset.

Source files
------------

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared types, constants and requantization helper for the NPU tile
package npu_pkg;

    localparam int DW    = 8;
    localparam int ACC_W = 32;
    localparam int EXT_W = ACC_W + 1;

    // Rounding unit and saturation bounds, all at the widened intermediate width
    localparam logic signed [EXT_W-1:0] RND_ONE = EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(64'sd1 <<< (DW - 1)));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN
    } npu_tile_state_e;

    // Round half-up, arithmetic shift, optional ReLU, saturate to DW bits
    function automatic logic [DW-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                              input logic [4:0] shift,
                                              input logic relu);
        logic signed [EXT_W-1:0] v;
        v = {acc[ACC_W-1], acc};
        if (shift != 5'd0) begin
            v = (v + (RND_ONE <<< (shift - 5'd1))) >>> shift;
        end
        if (relu && (v < 0)) begin
            v = '0;
        end
        if (v > SAT_MAX) begin
            v = SAT_MAX;
        end else if (v < SAT_MIN) begin
            v = SAT_MIN;
        end
        return v[DW-1:0];
    endfunction

endpackage

// File: rtl/npu_pe.sv
// rtl/npu_pe.sv - one output-stationary MAC cell of the systolic tile
module npu_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    output logic signed [DATA_WIDTH-1:0] a_out,
    output logic signed [DATA_WIDTH-1:0] b_out,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod = a_in * b_in;

    // Forward operands to neighbours and accumulate the sign-extended product
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (enable) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/npu_tile_os.sv
// rtl/npu_tile_os.sv - output-stationary systolic tile with stream in, requant and stream out
module npu_tile_os
    import npu_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [4:0]                          cfg_shift,
    input  logic                                cfg_relu,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic [(ROWS+COLS)*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                                s_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [COLS*DATA_WIDTH-1:0]          m_axis_tdata,
    output logic                                m_axis_tlast,
    output logic                                busy,
    output logic [15:0]                         k_count
);

    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    npu_tile_state_e state;
    logic [RW-1:0]   row;
    logic [RW-1:0]   nxt_row;
    logic [FW-1:0]   flush_cnt;
    logic [4:0]      shift_q;
    logic            relu_q;
    logic            hs;
    logic            drain_done;
    logic            pe_en;

    logic signed [DATA_WIDTH-1:0] a_inj [ROWS];
    logic signed [DATA_WIDTH-1:0] b_inj [COLS];
    logic signed [DATA_WIDTH-1:0] a_tap [ROWS];
    logic signed [DATA_WIDTH-1:0] b_tap [COLS];
    logic signed [DATA_WIDTH-1:0] a_h   [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] b_v   [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]  acc_w [ROWS][COLS];
    logic [COLS*DATA_WIDTH-1:0]   cur_data;
    logic [COLS*DATA_WIDTH-1:0]   nxt_data;

    assign s_axis_tready = (state == ST_IDLE) || (state == ST_LOAD);
    assign busy          = (state != ST_IDLE);
    assign hs            = s_axis_tvalid && s_axis_tready;
    assign pe_en         = (state != ST_DRAIN);
    assign nxt_row       = row + 1'b1;
    assign drain_done    = (state == ST_DRAIN) && m_axis_tvalid && m_axis_tready &&
                           (row == RW'(ROWS - 1));

    // Accepted beats enter the array; any non-handshake cycle injects zeros
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_inj[i] = hs ? s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            b_inj[j] = hs ? s_axis_tdata[(ROWS+j)*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : gen_a_skew
        if (gi == 0) begin : g_direct
            assign a_tap[gi] = a_inj[gi];
        end else begin : g_chain
            logic signed [DATA_WIDTH-1:0] sr [gi];
            // Delay row gi by gi cycles so diagonals meet in the right PE
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < gi; d++) sr[d] <= '0;
                end else begin
                    sr[0] <= a_inj[gi];
                    for (int d = 1; d < gi; d++) sr[d] <= sr[d-1];
                end
            end
            assign a_tap[gi] = sr[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : gen_b_skew
        if (gj == 0) begin : g_direct
            assign b_tap[gj] = b_inj[gj];
        end else begin : g_chain
            logic signed [DATA_WIDTH-1:0] sr [gj];
            // Delay column gj by gj cycles
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < gj; d++) sr[d] <= '0;
                end else begin
                    sr[0] <= b_inj[gj];
                    for (int d = 1; d < gj; d++) sr[d] <= sr[d-1];
                end
            end
            assign b_tap[gj] = sr[gj-1];
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : gen_row
        for (genvar gj = 0; gj < COLS; gj++) begin : gen_col
            logic signed [DATA_WIDTH-1:0] a_src;
            logic signed [DATA_WIDTH-1:0] b_src;
            if (gj == 0) begin : g_a_edge
                assign a_src = a_tap[gi];
            end else begin : g_a_mesh
                assign a_src = a_h[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_src = b_tap[gj];
            end else begin : g_b_mesh
                assign b_src = b_v[gi-1][gj];
            end
            npu_pe #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clear (drain_done),
                .enable(pe_en),
                .a_in  (a_src),
                .b_in  (b_src),
                .a_out (a_h[gi][gj]),
                .b_out (b_v[gi][gj]),
                .acc   (acc_w[gi][gj])
            );
        end
    end

    // Requantized view of the current row and the one after it, so DRAIN never bubbles
    always_comb begin
        cur_data = '0;
        nxt_data = '0;
        for (int j = 0; j < COLS; j++) begin
            cur_data[j*DATA_WIDTH +: DATA_WIDTH] = requant(acc_w[row][j], shift_q, relu_q);
            nxt_data[j*DATA_WIDTH +: DATA_WIDTH] = requant(acc_w[nxt_row][j], shift_q, relu_q);
        end
    end

    // Job sequencing: load K-slices, flush the skew, then drain rows with backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            row           <= '0;
            flush_cnt     <= '0;
            shift_q       <= '0;
            relu_q        <= 1'b0;
            k_count       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        shift_q <= cfg_shift;
                        relu_q  <= cfg_relu;
                        k_count <= 16'd1;
                        if (s_axis_tlast) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FW'(FLUSH_LEN - 1);
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (s_axis_tvalid) begin
                        if (k_count != 16'hFFFF) k_count <= k_count + 16'd1;
                        if (s_axis_tlast) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FW'(FLUSH_LEN - 1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) state <= ST_DRAIN;
                    else                 flush_cnt <= flush_cnt - 1'b1;
                end
                ST_DRAIN: begin
                    if (!m_axis_tvalid) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= cur_data;
                        m_axis_tlast  <= (row == RW'(ROWS - 1));
                    end else if (m_axis_tready) begin
                        if (row == RW'(ROWS - 1)) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tdata  <= '0;
                            m_axis_tlast  <= 1'b0;
                            row           <= '0;
                            state         <= ST_IDLE;
                        end else begin
                            row          <= nxt_row;
                            m_axis_tdata <= nxt_data;
                            m_axis_tlast <= (nxt_row == RW'(ROWS - 1));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_tile_os.sv
// tb/tb_npu_tile_os.sv - scoreboard testbench for the output-stationary NPU tile
module tb_npu_tile_os;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 8;

    typedef struct {
        logic [C*DW-1:0] data;
        bit              last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [4:0]           cfg_shift = '0;
    logic                 cfg_relu = 1'b0;
    logic                 s_axis_tvalid = 1'b0;
    logic                 s_axis_tready;
    logic [(R+C)*DW-1:0]  s_axis_tdata = '0;
    logic                 s_axis_tlast = 1'b0;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready = 1'b1;
    logic [C*DW-1:0]      m_axis_tdata;
    logic                 m_axis_tlast;
    logic                 busy;
    logic [15:0]          k_count;

    npu_tile_os #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_shift    (cfg_shift),
        .cfg_relu     (cfg_relu),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .k_count      (k_count)
    );

    always #5 clk = ~clk;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   hs_cyc     = 0;
    int   first_cyc  = 0;
    bit   lat_seen   = 1'b0;
    int   beats      = 0;
    int   bp_mode    = 0;
    int   pidx       = 0;
    exp_t sb[$];
    int   ja [8][R];
    int   jb [8][C];

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: plain matrix product then requant arithmetic
    function automatic longint ref_requant(input int s, input int sh, input bit rl);
        longint v;
        v = s;
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (rl && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    task automatic push_expected(input int k, input int sh, input bit rl);
        for (int r = 0; r < R; r++) begin
            exp_t e;
            e.data = '0;
            for (int j = 0; j < C; j++) begin
                int s;
                longint v;
                s = 0;
                for (int kk = 0; kk < k; kk++) s += ja[kk][r] * jb[kk][j];
                v = ref_requant(s, sh, rl);
                e.data[j*DW +: DW] = v[7:0];
            end
            e.last = (r == R - 1);
            sb.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready generator
    initial forever begin
        @(posedge clk);
        #1;
        case (bp_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'($urandom_range(0, 1));
            2: begin
                if (m_axis_tvalid) begin
                    m_axis_tready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
                    pidx++;
                end else begin
                    m_axis_tready = 1'b0;
                end
            end
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Output monitor: pop the scoreboard on every output handshake
    initial begin
        bit              stalled;
        logic [C*DW-1:0] held_data;
        bit              held_last;
        stalled = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else if (m_axis_tvalid) begin
                if (!lat_seen) begin
                    lat_seen  = 1'b1;
                    first_cyc = cyc;
                end
                chk("s_tready_low_in_drain", s_axis_tready, 0);
                if (stalled) begin
                    chk("hold_tdata", m_axis_tdata, held_data);
                    chk("hold_tlast", m_axis_tlast, held_last);
                end
                if (m_axis_tready) begin
                    chk("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("row_data", m_axis_tdata, e.data);
                        chk("row_last", m_axis_tlast, e.last);
                    end
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = m_axis_tdata;
                    held_last = m_axis_tlast;
                end
            end else begin
                if (stalled) chk("tvalid_dropped_while_stalled", 0, 1);
                stalled = 1'b0;
            end
        end
    end

    task automatic run_job(input int k, input int sh, input bit rl, input int nbub,
                           input int bpm, input int abort_after);
        int gap [8];
        int n;
        for (int i = 0; i < 8; i++) gap[i] = 0;
        if (k > 1) begin
            for (int i = 0; i < nbub; i++) gap[$urandom_range(1, k - 1)]++;
        end
        bp_mode  = bpm;
        pidx     = 0;
        lat_seen = 1'b0;
        beats    = 0;
        push_expected(k, sh, rl);
        for (int kk = 0; kk < k; kk++) begin
            for (int g = 0; g < gap[kk]; g++) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = {(R+C)*DW{1'b1}};
                @(posedge clk);
                #1;
            end
            for (int r = 0; r < R; r++) s_axis_tdata[r*DW +: DW] = 8'(ja[kk][r]);
            for (int j = 0; j < C; j++) s_axis_tdata[(R+j)*DW +: DW] = 8'(jb[kk][j]);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (kk == k - 1);
            if (kk == 0) begin
                cfg_shift = 5'(sh);
                cfg_relu  = rl;
            end else begin
                cfg_shift = 5'($urandom_range(0, 31));
                cfg_relu  = 1'($urandom_range(0, 1));
            end
            n = 0;
            while (!s_axis_tready && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("in_ready_timeout", n < 50, 1);
            @(posedge clk);
            #1;
            if (kk == k - 1) hs_cyc = cyc;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cfg_shift     = 5'($urandom_range(0, 31));
        cfg_relu      = 1'($urandom_range(0, 1));
        chk("busy_after_load", busy, 1);
        if (abort_after > 0) begin
            n = 0;
            while (beats < abort_after && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("abort_wait_timeout", n < 100, 1);
            bp_mode = 3;
            @(posedge clk);
            #1;
            rst = 1'b1;
            sb.delete();
            @(posedge clk);
            #1;
            chk("rst_tvalid", m_axis_tvalid, 0);
            chk("rst_tdata", m_axis_tdata, 0);
            chk("rst_busy", busy, 0);
            chk("rst_kcount", k_count, 0);
            chk("rst_s_tready", s_axis_tready, 1);
            @(posedge clk);
            #1;
            chk("rst_tvalid_2", m_axis_tvalid, 0);
            rst     = 1'b0;
            bp_mode = 0;
            return;
        end
        n = 0;
        while ((busy || sb.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("job_timeout", n < 300, 1);
        chk("latency", first_cyc - hs_cyc, R + C);
        chk("beats_per_job", beats, R);
        chk("k_count", k_count, k);
        chk("idle_s_tready", s_axis_tready, 1);
        chk("idle_tvalid", m_axis_tvalid, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("k_count_holds", k_count, k);
        bp_mode = 0;
    endtask

    task automatic fill_identity();
        for (int kk = 0; kk < 4; kk++) begin
            for (int r = 0; r < R; r++) ja[kk][r] = (kk + 1) * (r + 1);
            for (int j = 0; j < C; j++) jb[kk][j] = (kk == j) ? 1 : 0;
        end
    endtask

    task automatic fill_const(input int k, input int av, input int bv);
        for (int kk = 0; kk < k; kk++) begin
            for (int r = 0; r < R; r++) ja[kk][r] = av;
            for (int j = 0; j < C; j++) jb[kk][j] = bv;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_s_tready", s_axis_tready, 1);
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_tdata", m_axis_tdata, 0);
        chk("reset_tlast", m_axis_tlast, 0);
        chk("reset_busy", busy, 0);
        chk("reset_kcount", k_count, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        fill_identity();
        run_job(4, 0, 1'b0, 0, 0, 0);

        fill_const(4, -128, -128);
        run_job(4, 8, 1'b0, 0, 0, 0);
        fill_const(4, 127, -128);
        run_job(4, 8, 1'b0, 0, 0, 0);

        ja[0][0] = 1;  ja[0][1] = -1; ja[0][2] = 3;  ja[0][3] = -3;
        jb[0][0] = 3;  jb[0][1] = -3; jb[0][2] = 1;  jb[0][3] = 2;
        run_job(1, 1, 1'b1, 0, 0, 0);

        fill_identity();
        run_job(4, 0, 1'b0, 3, 0, 0);

        fill_identity();
        run_job(4, 2, 1'b0, 0, 2, 0);

        for (int t = 0; t < 8; t++) begin
            int k;
            k = $urandom_range(1, 8);
            for (int kk = 0; kk < k; kk++) begin
                for (int r = 0; r < R; r++) ja[kk][r] = int'($urandom_range(0, 255)) - 128;
                for (int j = 0; j < C; j++) jb[kk][j] = int'($urandom_range(0, 255)) - 128;
            end
            run_job(k, $urandom_range(0, 14), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4), 1, 0);
        end

        for (int kk = 0; kk < 2; kk++) begin
            for (int r = 0; r < R; r++) ja[kk][r] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < C; j++) jb[kk][j] = int'($urandom_range(0, 255)) - 128;
        end
        run_job(2, 0, 1'b0, 0, 0, 2);

        fill_const(1, 1, 1);
        run_job(1, 0, 1'b0, 0, 0, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", compared);
        $fatal(1, "timeout");
    end

endmodule
